// File: rtl/fm_tune_ctrl.sv
// fm_tune_ctrl: click-free retune sequencer for the FM transmitter.
// It owns the carrier frequency word and the PCM feed into the FM generator.
// A retune runs in four phases, each advancing only on sample_tick:
//   mute (attenuation ramps up), slew (bounded carrier steps),
//   settle (hold at target), unmute (attenuation ramps down).
//
// Ports:
//   clk_pcm     - sole clock (PCM domain)
//   rst         - synchronous, active-high reset
//   sample_tick - one-cycle strobe per audio sample; paces all sequencing
//   tune_valid  - tune request valid
//   tune_ready  - high while idle; a request is accepted on valid & ready
//   tune_freq   - requested carrier frequency, Hz
//   pcm_in      - signed audio sample from source
//   pcm_out     - signed, attenuated audio to the FM generator (registered)
//   cw_freq     - carrier frequency to the FM generator, Hz
//   busy        - retune sequence in progress
//   tune_done   - one-cycle pulse when a request completes
module fm_tune_ctrl #(
  parameter int unsigned       FREQ_W       = 32,
  parameter int unsigned       STEP_HZ      = 1000,
  parameter int unsigned       SETTLE_TICKS = 64,
  parameter int unsigned       ATT_MAX      = 15,
  parameter logic [FREQ_W-1:0] DEFAULT_FREQ = FREQ_W'(107900000)
) (
  input  logic              clk_pcm,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              tune_valid,
  output logic              tune_ready,
  input  logic [FREQ_W-1:0] tune_freq,
  input  logic [15:0]       pcm_in,
  output logic [15:0]       pcm_out,
  output logic [FREQ_W-1:0] cw_freq,
  output logic              busy,
  output logic              tune_done
);

  localparam int unsigned CntW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  localparam logic [3:0]        AttMax     = 4'(ATT_MAX);
  localparam logic [FREQ_W-1:0] StepF      = FREQ_W'(STEP_HZ);
  localparam logic [FREQ_W:0]   StepX      = (FREQ_W+1)'(STEP_HZ);
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StMute, StSlew, StSettle, StUnmute} state_e;

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] cw_q, cw_d;
  logic [FREQ_W-1:0] target_q, target_d;
  logic [3:0]        att_q, att_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       pcm_q, pcm_d;
  logic              done_q, done_d;

  // Distance to target at one extra bit so neither direction can wrap.
  logic [FREQ_W:0] diff;
  logic            slew_up;

  always_comb begin
    slew_up = (target_q > cw_q);
    if (slew_up) begin
      diff = {1'b0, target_q} - {1'b0, cw_q};
    end else begin
      diff = {1'b0, cw_q} - {1'b0, target_q};
    end
  end

  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    target_d = target_q;
    att_d    = att_q;
    cnt_d    = cnt_q;
    pcm_d    = pcm_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Acceptance does not wait for sample_tick.
        if (tune_valid) begin
          target_d = tune_freq;
          if (tune_freq == cw_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StMute;
          end
        end
      end
      StMute: begin
        if (sample_tick) begin
          att_d = att_q + 4'd1;
          if (att_q + 4'd1 == AttMax) begin
            state_d = StSlew;
          end
        end
      end
      StSlew: begin
        if (sample_tick) begin
          if (diff > StepX) begin
            cw_d = slew_up ? (cw_q + StepF) : (cw_q - StepF);
          end else begin
            cw_d    = target_q;
            cnt_d   = '0;
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (sample_tick) begin
          if (cnt_q == SettleLast) begin
            state_d = StUnmute;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StUnmute: begin
        if (sample_tick) begin
          att_d = att_q - 4'd1;
          if (att_q == 4'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Audio uses the attenuation in force before this tick's update.
    if (sample_tick) begin
      if (att_q == AttMax) begin
        pcm_d = '0;
      end else begin
        pcm_d = 16'($signed(pcm_in) >>> att_q);
      end
    end
  end

  always_ff @(posedge clk_pcm) begin
    if (rst) begin
      state_q  <= StIdle;
      cw_q     <= DEFAULT_FREQ;
      target_q <= DEFAULT_FREQ;
      att_q    <= '0;
      cnt_q    <= '0;
      pcm_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cw_q     <= cw_d;
      target_q <= target_d;
      att_q    <= att_d;
      cnt_q    <= cnt_d;
      pcm_q    <= pcm_d;
      done_q   <= done_d;
    end
  end

  assign tune_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign tune_done  = done_q;
  assign cw_freq    = cw_q;
  assign pcm_out    = pcm_q;

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Testbench for fm_tune_ctrl. The reference model derives, for each tick of a
// retune, the expected carrier and attenuation directly from the phase lengths
// (ATT_MAX mute ticks, ceil(distance/STEP) slew ticks, SETTLE_TICKS settle
// ticks, ATT_MAX unmute ticks) and checks every cycle.
module tb_fm_tune_ctrl;

  localparam int          A    = 15;
  localparam int          S    = 1000;
  localparam int          SET  = 64;
  localparam logic [31:0] DEF  = 32'd107900000;

  logic        clk_pcm = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        tune_valid;
  logic        tune_ready;
  logic [31:0] tune_freq;
  logic [15:0] pcm_in;
  logic [15:0] pcm_out;
  logic [31:0] cw_freq;
  logic        busy;
  logic        tune_done;

  fm_tune_ctrl dut (
    .clk_pcm     (clk_pcm),
    .rst         (rst),
    .sample_tick (sample_tick),
    .tune_valid  (tune_valid),
    .tune_ready  (tune_ready),
    .tune_freq   (tune_freq),
    .pcm_in      (pcm_in),
    .pcm_out     (pcm_out),
    .cw_freq     (cw_freq),
    .busy        (busy),
    .tune_done   (tune_done)
  );

  always #5 clk_pcm = ~clk_pcm;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_cw    = DEF;
  int          m_att   = 0;
  logic [15:0] m_pcm   = '0;
  bit          pcm_fixed = 1'b0;
  logic [15:0] pcm_fix_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_busy, input bit exp_done);
    chk({tag, "/cw"}, 64'(cw_freq), 64'(m_cw));
    chk({tag, "/busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, "/ready"}, 64'(tune_ready), 64'(!exp_busy));
    chk({tag, "/done"}, 64'(tune_done), 64'(exp_done));
    chk({tag, "/pcm"}, 64'(pcm_out), 64'(m_pcm));
  endtask

  // One clock cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit tick);
    sample_tick = tick;
    pcm_in = pcm_fixed ? pcm_fix_val : 16'($urandom);
    if (tick) begin
      if (m_att == A) m_pcm = '0;
      else            m_pcm = 16'($signed(pcm_in) >>> m_att);
    end
    @(posedge clk_pcm);
    #1;
    sample_tick = 1'b0;
  endtask

  // Issue a request for f1 and follow the whole retune tick by tick.
  task automatic run_tune(input logic [31:0] f1, input int gap_max, input bit fixed_gap,
                          input int abort_at, input bit hold_next,
                          input logic [31:0] fnext);
    longint f0, d, exp_cw;
    int     n, total, gap, exp_att;
    bit     up;
    tune_valid = 1'b1;
    tune_freq  = f1;
    cyc(1'($urandom_range(0, 1)));
    tune_valid = hold_next;
    tune_freq  = fnext;
    if (f1 == m_cw) begin
      chk_all("eq", 1'b0, 1'b1);
      cyc(1'b0);
      chk_all("eq_after", 1'b0, 1'b0);
      return;
    end
    chk_all("accept", 1'b1, 1'b0);
    f0    = longint'(m_cw);
    up    = (longint'(f1) > f0);
    d     = up ? (longint'(f1) - f0) : (f0 - longint'(f1));
    n     = int'((d + S - 1) / S);
    total = A + n + SET + A;
    for (int t = 1; t <= total; t++) begin
      gap = fixed_gap ? gap_max : $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0);
        chk_all("hold", 1'b1, 1'b0);
      end
      cyc(1'b1);
      if (t <= A) begin
        exp_att = t;
        exp_cw  = f0;
      end else if (t <= A + n) begin
        exp_att = A;
        if (t - A == n) exp_cw = longint'(f1);
        else            exp_cw = up ? f0 + longint'(t - A) * S : f0 - longint'(t - A) * S;
      end else if (t <= A + n + SET) begin
        exp_att = A;
        exp_cw  = longint'(f1);
      end else begin
        exp_att = A - (t - A - n - SET);
        exp_cw  = longint'(f1);
      end
      m_att = exp_att;
      m_cw  = 32'(exp_cw);
      chk_all("tick", t != total, t == total);
      if (t == abort_at) begin
        tune_valid = 1'b0;
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        m_cw  = DEF;
        m_att = 0;
        m_pcm = '0;
        chk_all("abort", 1'b0, 1'b0);
        cyc(1'b1);
        chk_all("post_abort", 1'b0, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    int          off;
    logic [31:0] f;
    rst         = 1'b1;
    sample_tick = 1'b0;
    tune_valid  = 1'b0;
    tune_freq   = '0;
    pcm_in      = '0;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    chk_all("reset", 1'b0, 1'b0);

    // Idle pass-through.
    pcm_fixed   = 1'b1;
    pcm_fix_val = 16'h4000;
    cyc(1'b1);
    chk("pass_4000", 64'(pcm_out), 64'h4000);
    chk_all("pass", 1'b0, 1'b0);

    // Upward tune, tick every 4 cycles.
    pcm_fixed = 1'b0;
    run_tune(32'd107905000, 3, 1'b1, -1, 1'b0, '0);
    chk("up_final", 64'(cw_freq), 64'd107905000);

    // Reset in the middle of the slew.
    run_tune(32'd108000000, 2, 1'b0, A + 3, 1'b0, '0);

    // Downward tune with full-scale negative audio; a second request is held
    // throughout and must only be taken once idle.
    pcm_fixed   = 1'b1;
    pcm_fix_val = 16'h8000;
    run_tune(32'd107897500, 1, 1'b0, -1, 1'b1, 32'd107910000);
    chk("down_final", 64'(cw_freq), 64'd107897500);
    pcm_fixed = 1'b0;
    run_tune(32'd107910000, 0, 1'b1, -1, 1'b0, '0);

    // Request for the current frequency.
    run_tune(32'd107910000, 2, 1'b0, -1, 1'b0, '0);

    // Randomized tunes.
    for (int k = 0; k < 5; k++) begin
      off = int'($urandom_range(0, 40000)) - 20000;
      f   = 32'(longint'(m_cw) + off);
      if ($urandom_range(0, 5) == 0) f = m_cw;
      run_tune(f, $urandom_range(0, 2), 1'b0, -1, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
